// File: rtl/uart_pkg.sv
// Shared definitions for the uart register bridge: FSM state encoding,
// default reply bytes and the command-byte layout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        READ,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // Bit 7 of the command byte selects write (1) or read (0).
    localparam int RW_BIT = 7;

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Byte-level uart handshake plus the simple register bus, bundled as one interface.
interface uart_reg_bridge_if;

    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_err;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    // The bridge is the slave; uart and register file together form the master side.
    modport slave (
        input  rx_data, rx_ready, rx_err, tx_busy, reg_rdata,
        output tx_data, tx_send, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport master (
        output rx_data, rx_ready, rx_err, tx_busy, reg_rdata,
        input  tx_data, tx_send, reg_addr, reg_wdata, reg_we, reg_re
    );

endinterface

// File: rtl/uart_tx_handshake.sv
// Holds tx_send with a stable byte until the transmitter has been seen idle and
// then busy, then waits for it to finish; done pulses as it returns to idle.
module uart_tx_handshake
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       tx_busy,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic       done
);

    state_t     state, state_next;
    logic [7:0] data_next;
    logic       seen_idle, seen_idle_next;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        data_next      = tx_data;
        seen_idle_next = seen_idle;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = SEND;
                    data_next      = tx_byte;
                    seen_idle_next = 1'b0;
                end
            end
            SEND: begin
                // A busy level left over from an earlier byte does not count as acceptance.
                if (!tx_busy) begin
                    seen_idle_next = 1'b1;
                end else if (seen_idle) begin
                    state_next = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so they all update from the same old values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data register is reset as well because it drives a visible output.
            state     <= IDLE;
            tx_data   <= '0;
            seen_idle <= 1'b0;
        end else begin
            state     <= state_next;
            tx_data   <= data_next;
            seen_idle <= seen_idle_next;
        end
    end

    assign tx_send = (state == SEND);
    assign done    = (state == WAIT_TX) && !tx_busy;

endmodule

// File: rtl/uart_reg_bridge.sv
// Register bridge: decodes read/write command frames from the uart receiver,
// drives a simple register bus and returns one reply byte per completed frame.
module uart_reg_bridge
    import uart_pkg::*;
#(
    parameter int         TimeoutWidth = 16,
    parameter int         Timeout      = 50000,
    parameter int         RdLatency    = 1,
    parameter logic [7:0] AckByte      = ACK_BYTE,
    parameter logic [7:0] NakByte      = NAK_BYTE
) (
    input  logic             clk,
    input  logic             reset,
    uart_reg_bridge_if.slave bus,
    output logic             busy,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(Timeout - 1);
    localparam logic [TimeoutWidth-1:0] ReadLast    = TimeoutWidth'(RdLatency);

    state_t                  state, state_next;
    logic [TimeoutWidth-1:0] cnt, cnt_next;
    logic [6:0]              addr, addr_next;
    logic [7:0]              wdata, wdata_next;
    logic                    overrun_next;
    logic                    rx_ok;
    logic                    hs_start;
    logic                    hs_done;
    logic [7:0]              hs_byte;

    assign rx_ok = bus.rx_ready && !bus.rx_err;

    // The counter times the data-byte gap in GET_DATA and the read latency in READ.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        addr_next    = addr;
        wdata_next   = wdata;
        overrun_next = overrun;
        hs_start     = 1'b0;
        hs_byte      = AckByte;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ok) begin
                    addr_next  = bus.rx_data[6:0];
                    cnt_next   = '0;
                    state_next = bus.rx_data[RW_BIT] ? GET_DATA : READ;
                end
            end
            GET_DATA: begin
                cnt_next = cnt + 1'b1;
                if (bus.rx_ready) begin
                    if (bus.rx_err) begin
                        hs_start   = 1'b1;
                        hs_byte    = NakByte;
                        state_next = SEND;
                    end else begin
                        wdata_next = bus.rx_data;
                        state_next = WRITE;
                    end
                end else if (cnt == TimeoutLast) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                hs_start   = 1'b1;
                hs_byte    = AckByte;
                state_next = SEND;
            end
            READ: begin
                cnt_next = cnt + 1'b1;
                if (cnt == ReadLast) begin
                    hs_start   = 1'b1;
                    hs_byte    = bus.reg_rdata;
                    state_next = SEND;
                end
            end
            SEND: begin
                // SEND here spans both handshake phases; the sub-module tracks them.
                if (hs_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.rx_ready && (state inside {WRITE, READ, SEND, WAIT_TX})) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            wdata   <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            addr    <= addr_next;
            wdata   <= wdata_next;
            overrun <= overrun_next;
        end
    end

    assign bus.reg_addr  = addr;
    assign bus.reg_wdata = wdata;
    assign bus.reg_we    = (state == WRITE);
    assign bus.reg_re    = (state == READ) && (cnt == '0);
    assign busy          = (state != IDLE);

    uart_tx_handshake u_tx (
        .clk     (clk),
        .reset   (reset),
        .start   (hs_start),
        .tx_byte (hs_byte),
        .tx_busy (bus.tx_busy),
        .tx_send (bus.tx_send),
        .tx_data (bus.tx_data),
        .done    (hs_done)
    );

endmodule
